// File: rtl/extension_bram_pkg.sv
// Shared constants and types for the extension BRAM arbiter.
package extension_bram_pkg;

  localparam int unsigned NUM_REQ           = 3;
  localparam int unsigned TAG_W             = 2;
  localparam int unsigned DEFAULT_DEPTH     = 1024;
  localparam int unsigned DEFAULT_ITEM_SIZE = 64;

  localparam logic [TAG_W-1:0] REQ_A = 2'd0;
  localparam logic [TAG_W-1:0] REQ_B = 2'd1;
  localparam logic [TAG_W-1:0] REQ_C = 2'd2;

  // Read-response tag carried alongside an issued access.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] id;
  } tag_t;

  function automatic logic [TAG_W-1:0] next_id(input logic [TAG_W-1:0] id);
    return (id >= REQ_C) ? REQ_A : TAG_W'(id + 1'b1);
  endfunction

endpackage

// File: rtl/ext_arb_select.sv
// Combinational requester selector: A-priority with starvation override, or pure round-robin.
module ext_arb_select
  import extension_bram_pkg::*;
#(
  parameter int unsigned CPU_PRIORITY = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [TAG_W-1:0]   rr_ptr,
  input  logic [1:0]         starved,
  output logic [NUM_REQ-1:0] grant
);

  logic             found;
  logic [TAG_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = REQ_A;
    if (CPU_PRIORITY != 0) begin
      // starved[0] belongs to B, starved[1] to C; a stale count never grants an idle port
      if (starved[0] && valid[REQ_B])      grant[REQ_B] = 1'b1;
      else if (starved[1] && valid[REQ_C]) grant[REQ_C] = 1'b1;
      else if (valid[REQ_A])               grant[REQ_A] = 1'b1;
      else if (valid[REQ_B] && (!valid[REQ_C] || rr_ptr != REQ_C)) grant[REQ_B] = 1'b1;
      else if (valid[REQ_C])               grant[REQ_C] = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = TAG_W'((32'(rr_ptr) + k) % NUM_REQ);
        if (!found && valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/extension_bram_arbiter.sv
// Three-requester arbiter for a single-port extension BRAM: grant, registered issue, tagged read return.
module extension_bram_arbiter
  import extension_bram_pkg::*;
#(
  parameter int unsigned ITEM_SIZE    = DEFAULT_ITEM_SIZE,
  parameter int unsigned DEPTH        = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W       = $clog2(DEPTH) + 1,
  parameter int unsigned CPU_PRIORITY = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*ITEM_SIZE-1:0] req_wdata,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [ITEM_SIZE-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [ITEM_SIZE-1:0]         mem_din,
  output logic                         mem_we,
  input  logic [ITEM_SIZE-1:0]         mem_dout
);

  localparam int unsigned      CNT_W = 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [TAG_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]     wait_b;
  logic [CNT_W-1:0]     wait_c;
  logic [1:0]           starved;
  logic [NUM_REQ-1:0]   grant;
  logic                 fire;
  logic [TAG_W-1:0]     grant_id;
  logic [ADDR_W-1:0]    sel_addr;
  logic [ITEM_SIZE-1:0] sel_wdata;
  logic                 sel_we;
  logic                 mem_we_q;
  tag_t                 tag_s1;
  tag_t                 tag_s2;

  function automatic logic [CNT_W-1:0] next_wait(input logic [CNT_W-1:0] cnt,
                                                 input logic valid, input logic granted);
    if (!valid || granted) return '0;
    if (cnt == LIMIT)      return cnt;
    return CNT_W'(cnt + 1'b1);
  endfunction

  assign starved = {wait_c == LIMIT, wait_b == LIMIT};

  ext_arb_select #(
    .CPU_PRIORITY(CPU_PRIORITY)
  ) u_select (
    .valid   (req_valid),
    .rr_ptr  (rr_ptr),
    .starved (starved),
    .grant   (grant)
  );

  assign req_ready = rst ? '0 : grant;
  assign fire      = |req_ready;

  // Mux the granted requester's payload onto the issue path.
  always_comb begin
    grant_id = REQ_A;
    if (grant[REQ_B])      grant_id = REQ_B;
    else if (grant[REQ_C]) grant_id = REQ_C;
    sel_addr  = req_addr[32'(grant_id)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[32'(grant_id)*ITEM_SIZE +: ITEM_SIZE];
    sel_we    = req_we[grant_id];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= REQ_A;
      wait_b   <= '0;
      wait_c   <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we_q <= 1'b0;
      tag_s1   <= '0;
      tag_s2   <= '0;
    end else begin
      wait_b        <= next_wait(wait_b, req_valid[REQ_B], grant[REQ_B]);
      wait_c        <= next_wait(wait_c, req_valid[REQ_C], grant[REQ_C]);
      mem_we_q      <= fire & sel_we;
      tag_s1.valid  <= fire & ~sel_we;
      tag_s1.id     <= grant_id;
      tag_s2        <= tag_s1;
      if (fire) begin
        mem_addr <= sel_addr;
        mem_din  <= sel_wdata;
        rr_ptr   <= next_id(grant_id);
      end
    end
  end

  // A write sitting on the port when reset hits must never reach the array.
  assign mem_we = mem_we_q & ~rst;

  always_comb begin
    rsp_valid = '0;
    if (tag_s2.valid && !rst) rsp_valid[tag_s2.id] = 1'b1;
  end

  assign rsp_rdata = mem_dout;

endmodule

// File: tb/tb_extension_bram_arbiter.sv
// Bench for extension_bram_arbiter: a priority instance and a round-robin instance side by side.
module tb_extension_bram_arbiter;

  localparam int unsigned IW  = 64;
  localparam int unsigned AW  = 11;
  localparam int          LIM = 8;

  typedef struct {
    logic       r;
    logic [2:0] v;
    logic [2:0] ep;
    logic [2:0] er;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    valid, we;
  logic [3*AW-1:0] addr;
  logic [3*IW-1:0] wdata;

  logic [2:0] ready_p, ready_r, rsp_p, rsp_r;
  logic [IW-1:0] rdata_p, rdata_r, din_p, din_r, dout_p, dout_r;
  logic [AW-1:0] maddr_p, maddr_r;
  logic          mwe_p, mwe_r;

  logic [IW-1:0] bram_p [2048];
  logic [IW-1:0] bram_r [2048];

  int checks = 0;
  int failures = 0;

  // reference model state, index 0 = priority instance, 1 = round-robin instance
  int          wb [2];
  int          wc [2];
  int          rr [2];
  logic [IW-1:0] refmem [2][8];
  bit          known [2][8];
  bit          ev  [2][4];
  int          eid [2][4];
  logic [IW-1:0] ed [2][4];
  bit          edk [2][4];

  vec_t tbl[$];

  always #5 clk = ~clk;

  extension_bram_arbiter #(.ITEM_SIZE(IW), .DEPTH(1024), .ADDR_W(AW), .CPU_PRIORITY(1), .STARVE_LIMIT(LIM)) dut_p (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready_p), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .rsp_valid(rsp_p), .rsp_rdata(rdata_p), .mem_addr(maddr_p), .mem_din(din_p),
    .mem_we(mwe_p), .mem_dout(dout_p));

  extension_bram_arbiter #(.ITEM_SIZE(IW), .DEPTH(1024), .ADDR_W(AW), .CPU_PRIORITY(0), .STARVE_LIMIT(LIM)) dut_r (
    .clk(clk), .rst(rst), .req_valid(valid), .req_ready(ready_r), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .rsp_valid(rsp_r), .rsp_rdata(rdata_r), .mem_addr(maddr_r), .mem_din(din_r),
    .mem_we(mwe_r), .mem_dout(dout_r));

  always @(posedge clk) begin
    if (mwe_p) bram_p[maddr_p] <= din_p;
    dout_p <= bram_p[maddr_p];
    if (mwe_r) bram_r[maddr_r] <= din_r;
    dout_r <= bram_r[maddr_r];
  end

  task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, want);
    end
  endtask

  task automatic chk64(input string nm, input logic [IW-1:0] act, input logic [IW-1:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] v, input logic [2:0] w,
                       input logic [AW-1:0] a, input logic [IW-1:0] d);
    rst   = r;
    valid = v;
    we    = w;
    addr  = {a, a, a};
    wdata = {d, d, d};
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic [2:0] v, input logic [2:0] ep, input logic [2:0] er);
    vec_t e;
    e.r = r; e.v = v; e.ep = ep; e.er = er;
    tbl.push_back(e);
  endtask

  // Arbitration rules stated directly: -1 means nobody is granted.
  function automatic int pick(bit prio, logic [2:0] v, int b, int c, int r);
    if (prio) begin
      if (v[1] && b == LIM) return 1;
      if (v[2] && c == LIM) return 2;
      if (v[0]) return 0;
      if (v[1] && v[2]) return (r == 2) ? 2 : 1;
      if (v[1]) return 1;
      if (v[2]) return 2;
      return -1;
    end
    for (int j = 0; j < 3; j++) if (v[(r + j) % 3]) return (r + j) % 3;
    return -1;
  endfunction

  task automatic model_cycle(input int k, input int t, input logic [2:0] rdy,
                             input logic [2:0] rv, input logic [IW-1:0] rd);
    int g, s, a;
    string tagn;
    tagn = (k == 0) ? "p" : "r";
    g = pick(k == 0, valid, wb[k], wc[k], rr[k]);
    chk3($sformatf("rand_ready_%s t=%0d", tagn, t), rdy, (g < 0) ? 3'b000 : 3'(1 << g));
    s = t % 4;
    if (ev[k][s]) begin
      chk3($sformatf("rand_rsp_valid_%s t=%0d", tagn, t), rv, 3'(1 << eid[k][s]));
      if (edk[k][s]) chk64($sformatf("rand_rdata_%s t=%0d", tagn, t), rd, ed[k][s]);
    end else begin
      chk3($sformatf("rand_rsp_idle_%s t=%0d", tagn, t), rv, 3'b000);
    end
    ev[k][s] = 1'b0;
    wb[k] = (!valid[1] || g == 1) ? 0 : ((wb[k] < LIM) ? wb[k] + 1 : wb[k]);
    wc[k] = (!valid[2] || g == 2) ? 0 : ((wc[k] < LIM) ? wc[k] + 1 : wc[k]);
    if (g >= 0) begin
      rr[k] = (g + 1) % 3;
      a = int'(addr[g*AW +: AW]) - 16;
      if (we[g]) begin
        refmem[k][a] = wdata[g*IW +: IW];
        known[k][a]  = 1'b1;
      end else begin
        ev[k][(t + 2) % 4]  = 1'b1;
        eid[k][(t + 2) % 4] = g;
        ed[k][(t + 2) % 4]  = refmem[k][a];
        edk[k][(t + 2) % 4] = known[k][a];
      end
    end
  endtask

  initial begin
    // {rst, valid, expected ready (priority), expected ready (round-robin)}
    add(1, 3'b111, 3'b000, 3'b000);
    for (int i = 0; i < 12; i++)
      add(0, 3'b111, (i < 8) ? 3'b001 : (i == 8) ? 3'b010 : (i == 9) ? 3'b100 : 3'b001,
          3'(1 << (i % 3)));
    add(1, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) add(0, 3'b011, 3'b001, (i % 2 == 0) ? 3'b001 : 3'b010);
    add(0, 3'b001, 3'b001, 3'b001);
    for (int i = 0; i < 9; i++)
      add(0, 3'b011, (i == 8) ? 3'b010 : 3'b001, (i % 2 == 0) ? 3'b010 : 3'b001);
    add(1, 3'b000, 3'b000, 3'b000);
    for (int i = 0; i < 7; i++) add(0, 3'b011, 3'b001, (i % 2 == 0) ? 3'b001 : 3'b010);
    add(0, 3'b001, 3'b001, 3'b001);
    add(0, 3'b011, 3'b001, 3'b010);
    add(0, 3'b111, 3'b001, 3'b100);
    add(0, 3'b110, 3'b010, 3'b010);
    add(0, 3'b110, 3'b100, 3'b100);
    add(0, 3'b110, 3'b010, 3'b010);

    drive(1, 3'b111, 3'b000, '0, '0);
    repeat (3) step();
    @(negedge clk);
    chk3("reset_ready", ready_p, 3'b000);
    chk3("reset_rsp", rsp_p, 3'b000);
    chk3("reset_mem_we", {2'b00, mwe_p}, 3'b000);

    step(); drive(0, 3'b000, 3'b000, '0, '0);
    @(negedge clk);
    chk64("reset_mem_addr", 64'(maddr_p), 64'd0);
    chk64("reset_mem_din", din_p, 64'd0);

    // A write then A read of the same word
    step(); drive(0, 3'b001, 3'b001, 11'd5, 64'hDEAD);
    @(negedge clk);
    chk3("a_wr_ready_p", ready_p, 3'b001);
    chk3("a_wr_ready_r", ready_r, 3'b001);
    step(); drive(0, 3'b001, 3'b000, 11'd5, '0);
    @(negedge clk);
    chk3("a_wr_issue_we", {2'b00, mwe_p}, 3'b001);
    chk64("a_wr_issue_addr", 64'(maddr_p), 64'd5);
    chk64("a_wr_issue_din", din_p, 64'hDEAD);
    chk3("a_rd_ready", ready_p, 3'b001);
    step(); drive(0, 3'b000, 3'b000, '0, '0);
    @(negedge clk);
    chk3("a_rd_issue_we", {2'b00, mwe_p}, 3'b000);
    chk3("a_rd_rsp_early", rsp_p, 3'b000);
    step(); @(negedge clk);
    chk3("a_rd_rsp_p", rsp_p, 3'b001);
    chk64("a_rd_data_p", rdata_p, 64'hDEAD);
    chk3("a_rd_rsp_r", rsp_r, 3'b001);
    chk64("a_rd_data_r", rdata_r, 64'hDEAD);
    step(); @(negedge clk);
    chk3("a_rd_rsp_pulse", rsp_p, 3'b000);
    chk64("idle_addr_hold", 64'(maddr_p), 64'd5);

    // B write followed immediately by C read of the same address
    step(); drive(0, 3'b010, 3'b010, 11'd3, 64'h11);
    @(negedge clk);
    chk3("b_wr_ready", ready_p, 3'b010);
    step(); drive(0, 3'b100, 3'b000, 11'd3, '0);
    @(negedge clk);
    chk3("c_rd_ready_p", ready_p, 3'b100);
    chk3("c_rd_ready_r", ready_r, 3'b100);
    step(); drive(0, 3'b000, 3'b000, '0, '0);
    step(); @(negedge clk);
    chk3("c_rd_rsp_p", rsp_p, 3'b100);
    chk64("c_rd_data_p", rdata_p, 64'h11);
    chk3("c_rd_rsp_r", rsp_r, 3'b100);
    chk64("c_rd_data_r", rdata_r, 64'h11);

    // Reads in flight when reset arrives
    step(); drive(0, 3'b100, 3'b000, 11'd3, '0);
    @(negedge clk);
    chk3("rst_seq_c_ready", ready_p, 3'b100);
    step(); drive(0, 3'b101, 3'b000, 11'd5, '0);
    @(negedge clk);
    chk3("rst_seq_a_ready", ready_p, 3'b001);
    step(); drive(1, 3'b101, 3'b000, 11'd5, '0);
    @(negedge clk);
    chk3("rst_seq_ready0", ready_p, 3'b000);
    chk3("rst_seq_rsp0_p", rsp_p, 3'b000);
    chk3("rst_seq_rsp0_r", rsp_r, 3'b000);
    chk3("rst_seq_we0", {2'b00, mwe_p}, 3'b000);
    step(); @(negedge clk);
    chk3("rst_seq_ready1", ready_p, 3'b000);
    chk3("rst_seq_rsp1", rsp_p, 3'b000);
    step(); drive(0, 3'b000, 3'b000, '0, '0);
    @(negedge clk);
    chk3("rst_seq_rsp2_p", rsp_p, 3'b000);
    chk3("rst_seq_rsp2_r", rsp_r, 3'b000);
    chk64("rst_seq_wait_b", 64'(dut_p.wait_b), 64'd0);
    chk64("rst_seq_wait_c", 64'(dut_p.wait_c), 64'd0);
    chk64("rst_seq_mem_addr", 64'(maddr_p), 64'd0);
    step(); @(negedge clk);
    chk3("rst_seq_rsp3", rsp_p, 3'b000);

    // A write whose issue cycle coincides with reset must be dropped
    step(); drive(0, 3'b001, 3'b001, 11'd40, 64'h55);
    @(negedge clk);
    chk3("fw_first_ready", ready_p, 3'b001);
    step(); drive(0, 3'b001, 3'b001, 11'd40, 64'h77);
    @(negedge clk);
    chk3("fw_second_ready", ready_p, 3'b001);
    step(); drive(1, 3'b000, 3'b000, '0, '0);
    @(negedge clk);
    chk3("fw_we_forced_p", {2'b00, mwe_p}, 3'b000);
    chk3("fw_we_forced_r", {2'b00, mwe_r}, 3'b000);
    step(); drive(0, 3'b001, 3'b000, 11'd40, '0);
    @(negedge clk);
    chk3("fw_read_ready", ready_p, 3'b001);
    step(); drive(0, 3'b000, 3'b000, '0, '0);
    step(); @(negedge clk);
    chk3("fw_read_rsp", rsp_p, 3'b001);
    chk64("fw_read_data_p", rdata_p, 64'h55);
    chk64("fw_read_data_r", rdata_r, 64'h55);

    // Grant sequences from the vector table
    foreach (tbl[i]) begin
      step();
      drive(tbl[i].r, tbl[i].v, 3'b000, '0, '0);
      @(negedge clk);
      chk3($sformatf("tbl_p[%0d]", i), ready_p, tbl[i].ep);
      chk3($sformatf("tbl_r[%0d]", i), ready_r, tbl[i].er);
    end

    // Random traffic against the reference model
    step(); drive(1, 3'b000, 3'b000, '0, '0);
    step();
    for (int k = 0; k < 2; k++) begin
      wb[k] = 0; wc[k] = 0; rr[k] = 0;
      for (int j = 0; j < 8; j++) begin refmem[k][j] = '0; known[k][j] = 1'b0; end
      for (int j = 0; j < 4; j++) begin ev[k][j] = 1'b0; eid[k][j] = 0; ed[k][j] = '0; edk[k][j] = 1'b0; end
    end
    for (int t = 0; t < 400; t++) begin
      step();
      rst   = 1'b0;
      valid = 3'($urandom);
      we    = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        addr[i*AW +: AW]  = AW'(16 + $urandom_range(0, 7));
        wdata[i*IW +: IW] = {$urandom, $urandom};
      end
      @(negedge clk);
      model_cycle(0, t, ready_p, rsp_p, rdata_p);
      model_cycle(1, t, ready_r, rsp_r, rdata_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
